// File: rtl/hawk_pkg.sv
// Shared definitions for the HAWK pedestrian-call unit: FSM state codes and
// default timing parameters.
package hawk_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVE   = 2'd2,
      LOCKOUT = 2'd3
   } state_e;

   localparam int DEB_CYCLES_DEF     = 4;
   localparam int LOCKOUT_CYCLES_DEF = 8;

endpackage

// File: rtl/hawk_debounce.sv
// Two-flop synchronizer plus level debouncer for the raw crosswalk button;
// emits a one-cycle pulse on each accepted rising level.
module hawk_debounce #(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic BTN,
   output logic deb_lvl,
   output logic press_evt
);

   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic          sync1_q, btn_s_q;
   logic          lvl_q, lvl_d;
   logic          lvl_dly_q;
   logic [CW-1:0] cnt_q, cnt_d;

   // A level change is accepted on the edge after the counter has seen
   // DEB_CYCLES mismatching samples, i.e. DEB_CYCLES+1 in a row.
   always_comb begin
      lvl_d = lvl_q;
      cnt_d = '0;
      if (btn_s_q != lvl_q) begin
         if (cnt_q == CW'(DEB_CYCLES)) begin
            lvl_d = ~lvl_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= 1'b0;
         btn_s_q   <= 1'b0;
         lvl_q     <= 1'b0;
         lvl_dly_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         sync1_q   <= BTN;
         btn_s_q   <= sync1_q;
         lvl_q     <= lvl_d;
         lvl_dly_q <= lvl_q;
         cnt_q     <= cnt_d;
      end
   end

   assign deb_lvl   = lvl_q;
   assign press_evt = lvl_q & ~lvl_dly_q;

endmodule

// File: rtl/hawk_ped_request.sv
// Pedestrian call unit: latches a debounced press, holds YP until the
// controller walks, then enforces a post-crossing lockout before the next call.
module hawk_ped_request
   import hawk_pkg::*;
#(
   parameter int DEB_CYCLES     = DEB_CYCLES_DEF,
   parameter int LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       BTN,
   input  logic       W,
   input  logic       DNW,
   output logic       YP,
   output logic       ACK_LAMP,
   output logic [1:0] present_state
);

   localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

   state_e        state_q, state_d;
   logic          pend_q, pend_d;
   logic [LW-1:0] lock_q, lock_d;
   logic          deb_lvl, press_evt, press;

   hawk_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_debounce (
      .clk       (clk),
      .rst_n     (rst_n),
      .BTN       (BTN),
      .deb_lvl   (deb_lvl),
      .press_evt (press_evt)
   );

   assign press = press_evt & deb_lvl;

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      lock_d  = lock_q;
      case (state_q)
         IDLE: begin
            if (press) state_d = REQ;
         end
         REQ: begin
            if (W) state_d = SERVE;
         end
         SERVE: begin
            if (press) pend_d = 1'b1;
            if (!W && DNW) begin
               state_d = LOCKOUT;
               lock_d  = LW'(LOCKOUT_CYCLES - 1);
            end
         end
         LOCKOUT: begin
            // A press landing on the final lockout cycle still counts.
            if (lock_q == '0) begin
               pend_d  = 1'b0;
               state_d = (pend_q || press) ? REQ : IDLE;
            end else begin
               lock_d = lock_q - 1'b1;
               if (press) pend_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pend_q  <= 1'b0;
         lock_q  <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         lock_q  <= lock_d;
      end
   end

   assign YP            = (state_q == REQ);
   assign ACK_LAMP      = (state_q == REQ) || pend_q;
   assign present_state = state_q;

endmodule

// File: tb/tb_hawk_ped_request.sv
// Bench for hawk_ped_request: directed scenarios plus randomized button and
// controller activity, checked every cycle against a behavioural model.
module tb_hawk_ped_request;

   localparam int DEB  = 4;
   localparam int LOCK = 8;
   localparam int P_IDLE = 0, P_REQ = 1, P_SERVE = 2, P_LOCK = 3;

   logic       clk, rst_n, BTN, W, DNW;
   logic       YP, ACK_LAMP;
   logic [1:0] present_state;
   bit         clk_run;

   int n_vec, n_err;

   hawk_ped_request #(
      .DEB_CYCLES     (DEB),
      .LOCKOUT_CYCLES (LOCK)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .BTN           (BTN),
      .W             (W),
      .DNW           (DNW),
      .YP            (YP),
      .ACK_LAMP      (ACK_LAMP),
      .present_state (present_state)
   );

   always begin
      #5;
      if (clk_run) clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got %0d vectors expected completion", n_vec);
      $fatal(1, "watchdog");
   end

   // Behavioural model: raw-sample history, run-length debounce, phase tracking
   bit m_hist[$];
   bit m_deb, m_deb_old;
   int m_run, m_phase, m_lock_end, m_n;
   bit m_pend;

   task automatic model_reset();
      m_hist.delete();
      m_deb = 0; m_deb_old = 0; m_run = 0;
      m_phase = P_IDLE; m_pend = 0; m_lock_end = 0; m_n = 0;
   endtask

   task automatic model_step();
      bit seen_s, press;
      seen_s = (m_hist.size() >= 2) ? m_hist[m_hist.size() - 2] : 1'b0;
      press  = m_deb && !m_deb_old;
      m_hist.push_back(BTN);
      if (m_hist.size() > 3) void'(m_hist.pop_front());
      m_run = (seen_s != m_deb) ? m_run + 1 : 0;
      m_deb_old = m_deb;
      if (m_run == DEB + 1) begin
         m_deb = !m_deb;
         m_run = 0;
      end
      case (m_phase)
         P_IDLE:  if (press) m_phase = P_REQ;
         P_REQ:   if (W) m_phase = P_SERVE;
         P_SERVE: begin
            if (press) m_pend = 1;
            if (!W && DNW) begin
               m_phase    = P_LOCK;
               m_lock_end = m_n + LOCK;
            end
         end
         default: begin
            if (m_n == m_lock_end) begin
               m_phase = (m_pend || press) ? P_REQ : P_IDLE;
               m_pend  = 0;
            end else if (press) m_pend = 1;
         end
      endcase
      m_n++;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      check("model_YP", int'(YP), int'(m_phase == P_REQ));
      check("model_ACK_LAMP", int'(ACK_LAMP), int'(m_phase == P_REQ || m_pend));
      check("model_state", int'(present_state), m_phase);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_step();
      compare_model();
   endtask

   initial begin
      int rise, cnt3, nz, btn_hold, w_hold;
      n_vec = 0; n_err = 0;
      clk = 0; clk_run = 1; rst_n = 0; BTN = 0; W = 0; DNW = 1;
      model_reset();
      #3;
      check("reset_YP", int'(YP), 0);
      check("reset_ACK", int'(ACK_LAMP), 0);
      check("reset_state", int'(present_state), 0);
      @(negedge clk);
      rst_n = 1;

      // Clean press: YP appears 7 edges after BTN is first sampled high
      BTN = 1; rise = -1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (YP && rise < 0) rise = i;
      end
      check("press_latency", rise, 7);
      check("press_lamp", int'(ACK_LAMP), 1);
      BTN = 0;
      tick(); tick();
      W = 1; DNW = 0;
      tick();
      check("serve_state", int'(present_state), 2);
      check("serve_YP", int'(YP), 0);

      // Served cycle and lockout length
      for (int i = 0; i < 5; i++) tick();
      W = 0; DNW = 1; cnt3 = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (present_state == 2'd3) cnt3++;
         if (YP) cnt3 += 100;
      end
      check("lockout_len", cnt3, 8);
      check("lockout_exit_idle", int'(present_state), 0);

      // Bounce rejection
      nz = 0;
      for (int i = 0; i < 8; i++) begin
         BTN = ~BTN;
         tick();
         if (YP || present_state != 2'd0) nz++;
      end
      BTN = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (YP || present_state != 2'd0) nz++;
      end
      check("bounce_idle", nz, 0);

      // Press during SERVE becomes a pending call served after lockout
      BTN = 1;
      for (int i = 0; i < 8; i++) tick();
      check("req_again", int'(present_state), 1);
      W = 1; DNW = 0;
      tick();
      BTN = 0;
      for (int i = 0; i < 8; i++) tick();
      check("serve_no_lamp", int'(ACK_LAMP), 0);
      BTN = 1;
      for (int i = 0; i < 10; i++) tick();
      check("pend_lamp", int'(ACK_LAMP), 1);
      check("pend_state", int'(present_state), 2);
      W = 0; DNW = 1;
      tick();
      check("pend_lock_entry", int'(present_state), 3);
      for (int i = 0; i < 7; i++) tick();
      check("pend_lock_last", int'(present_state), 3);
      tick();
      check("pend_req_state", int'(present_state), 1);
      check("pend_req_YP", int'(YP), 1);

      // Press landing on the final lockout cycle
      W = 1; DNW = 0;
      tick();
      BTN = 0;
      for (int i = 0; i < 8; i++) tick();
      W = 0; DNW = 1;
      tick();
      check("edge_lock_entry", int'(present_state), 3);
      BTN = 1;
      for (int i = 0; i < 7; i++) tick();
      check("edge_lock_lamp", int'(ACK_LAMP), 0);
      check("edge_lock_state", int'(present_state), 3);
      tick();
      check("edge_req_state", int'(present_state), 1);
      check("edge_req_YP", int'(YP), 1);

      // Asynchronous reset with the clock stopped while in REQ
      clk_run = 0;
      #2;
      rst_n = 0;
      #1;
      check("async_YP", int'(YP), 0);
      check("async_ACK", int'(ACK_LAMP), 0);
      check("async_state", int'(present_state), 0);
      model_reset();
      BTN = 0; W = 0; DNW = 1;
      #5;
      clk_run = 1;
      @(negedge clk);
      rst_n = 1;

      // Randomized button and controller activity
      btn_hold = 0; w_hold = 0;
      for (int i = 0; i < 2500; i++) begin
         if (btn_hold == 0) begin
            BTN = 1'($urandom_range(0, 1));
            btn_hold = $urandom_range(1, 12);
         end
         if (w_hold == 0) begin
            W = 1'($urandom_range(0, 1));
            DNW = W ? 1'b0 : 1'($urandom_range(0, 3) != 0);
            w_hold = $urandom_range(1, 20);
         end
         btn_hold--; w_hold--;
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
